// File: rtl/fft_twiddle_sequencer.sv
// Radix-2 DIT FFT twiddle/index sequencer: walks all stages over a synchronous
// twiddle ROM and hands aligned butterfly descriptors to the datapath via a small FIFO.
module fft_twiddle_sequencer #(
    parameter int LOG2N      = 5,
    parameter int ADDR_W     = 5,
    parameter int TW_W       = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int DRAIN_CYC  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [TW_W-1:0]   rom_data,
    output logic              bf_valid,
    input  logic              bf_ready,
    output logic [TW_W-1:0]   bf_tw,
    output logic [ADDR_W-1:0] bf_top,
    output logic [ADDR_W-1:0] bf_bot,
    output logic [2:0]        bf_stage,
    output logic              bf_last
);

    localparam int BF_W  = LOG2N - 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int DRN_W = $clog2(DRAIN_CYC + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] top;
        logic [ADDR_W-1:0] bot;
        logic [2:0]        stage;
        logic              last;
    } meta_t;

    typedef struct packed {
        logic [TW_W-1:0] tw;
        meta_t           meta;
    } entry_t;

    state_t            state_q, state_d;
    logic [2:0]        stage_q, stage_d;
    logic [BF_W-1:0]   bfly_q, bfly_d;
    logic [DRN_W-1:0]  drain_q, drain_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;

    logic              v1_q, v1_d, v2_q, v2_d;
    meta_t             meta1_q, meta1_d, meta2_q, meta2_d;

    entry_t            mem_q [FIFO_DEPTH];
    entry_t            mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [2:0]        iss_stage;
    logic [BF_W-1:0]   iss_b;
    logic [ADDR_W-1:0] pow, mask, k, iss_addr, iss_top;
    meta_t             iss_meta;
    logic              credit_ok, empty_all, drain_end, more_stages, issue;
    logic              wr, pop;
    entry_t            head;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // The last drain cycle issues butterfly 0 of the next stage directly, so the
    // issue side looks one stage ahead while in DRAIN.
    always_comb begin
        iss_stage = stage_q;
        iss_b     = bfly_q;
        if (state_q == S_DRAIN) begin
            iss_stage = stage_q + 3'd1;
            iss_b     = '0;
        end
        pow            = ADDR_W'(1) << iss_stage;
        mask           = pow - ADDR_W'(1);
        k              = ADDR_W'(iss_b) & mask;
        iss_addr       = mask + k;
        iss_top        = ((ADDR_W'(iss_b) >> iss_stage) << (iss_stage + 3'd1)) | k;
        iss_meta.top   = iss_top;
        iss_meta.bot   = iss_top + pow;
        iss_meta.stage = iss_stage;
        iss_meta.last  = (iss_b == '1);
    end

    always_comb begin
        credit_ok   = (({1'b0, count_q} + (CNT_W+1)'(v1_q) + (CNT_W+1)'(v2_q))
                       < (CNT_W+1)'(FIFO_DEPTH));
        empty_all   = (count_q == '0) && !v1_q && !v2_q;
        drain_end   = (state_q == S_DRAIN) && empty_all && (drain_q == DRN_W'(DRAIN_CYC - 1));
        more_stages = (stage_q < 3'(LOG2N - 1));
        issue       = ((state_q == S_RUN) && credit_ok) || (drain_end && more_stages);
    end

    always_comb begin
        state_d = state_q;
        stage_d = stage_q;
        bfly_d  = bfly_q;
        drain_d = drain_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_RUN;
                    stage_d = '0;
                    bfly_d  = '0;
                    drain_d = '0;
                end
            end
            S_RUN: begin
                if (issue) begin
                    bfly_d = bfly_q + BF_W'(1);
                    if (bfly_q == '1) begin
                        state_d = S_DRAIN;
                        drain_d = '0;
                    end
                end
            end
            S_DRAIN: begin
                if (!empty_all) begin
                    drain_d = '0;
                end else if (drain_end) begin
                    drain_d = '0;
                    if (more_stages) begin
                        stage_d = stage_q + 3'd1;
                        bfly_d  = BF_W'(1);
                        state_d = S_RUN;
                    end else begin
                        state_d = S_DONE;
                    end
                end else begin
                    drain_d = drain_q + DRN_W'(1);
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rom_addr_d = issue ? iss_addr : rom_addr_q;
        v1_d       = issue;
        meta1_d    = issue ? iss_meta : meta1_q;
        v2_d       = v1_q;
        meta2_d    = meta1_q;
    end

    always_comb begin
        wr       = v2_q;
        pop      = (count_q != '0) && bf_ready;
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr) begin
            mem_d[wr_ptr_q] = '{tw: rom_data, meta: meta2_q};
            wr_ptr_d        = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({wr, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            stage_q    <= '0;
            bfly_q     <= '0;
            drain_q    <= '0;
            rom_addr_q <= '0;
            v1_q       <= 1'b0;
            v2_q       <= 1'b0;
            meta1_q    <= '0;
            meta2_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            bfly_q     <= bfly_d;
            drain_q    <= drain_d;
            rom_addr_q <= rom_addr_d;
            v1_q       <= v1_d;
            v2_q       <= v2_d;
            meta1_q    <= meta1_d;
            meta2_q    <= meta2_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    always_comb begin
        head     = mem_q[rd_ptr_q];
        busy     = (state_q == S_RUN) || (state_q == S_DRAIN);
        done     = (state_q == S_DONE);
        rom_addr = rom_addr_q;
        bf_valid = (count_q != '0);
        bf_tw    = bf_valid ? head.tw         : '0;
        bf_top   = bf_valid ? head.meta.top   : '0;
        bf_bot   = bf_valid ? head.meta.bot   : '0;
        bf_stage = bf_valid ? head.meta.stage : '0;
        bf_last  = bf_valid ? head.meta.last  : 1'b0;
    end

endmodule

// File: doc/fft_twiddle_sequencer.md
# fft_twiddle_sequencer

- Sequences a full radix-2 DIT FFT pass over the synchronous-read real-twiddle ROM (5-bit address, 16-bit data, 1-cycle read latency).
- For every butterfly it generates the ROM address and the top/bottom operand indices, then aligns them with the returned twiddle.
- It presents the result to the butterfly datapath through a credit-protected output FIFO with valid/ready, and inserts a drain gap between stages.

## Interface
- LOG2N, 5, FFT size exponent; N = 32 points, N/2 = 16 butterflies per stage, LOG2N stages.
- ADDR_W, 5, ROM address width and index width.
- TW_W, 16, twiddle width (Q8 signed, passed through unmodified).
- FIFO_DEPTH, 4, output FIFO entries.
- DRAIN_CYC, 4, idle cycles inserted after a stage fully drains.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a pass; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until DONE.
- done  out  1  one-cycle pulse at end of pass.
- rom_addr  out  ADDR_W  registered ROM address.
- rom_data  in  TW_W  ROM output; valid one cycle after rom_addr.
- bf_valid  out  1  FIFO head valid.
- bf_ready  in  1  datapath accepts head.
- bf_tw  out  TW_W  twiddle for head butterfly.
- bf_top, bf_bot  out  ADDR_W each  operand indices.
- bf_stage  out  3  stage number 0..LOG2N-1.
- bf_last  out  1  head is butterfly 15 of its stage.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
  - IDLE -> RUN on start; stage s=0, butterfly b=0.
  - RUN issues butterflies.
  - After issuing b=15: RUN -> DRAIN.
  - DRAIN waits until the FIFO is empty and inflight=0, then counts DRAIN_CYC cycles.
  - When the count ends: if s<LOG2N-1, increment s, clear b, go to RUN; otherwise go to DONE.
  - DONE lasts one cycle with done=1, then goes to IDLE.
- Per-butterfly arithmetic:
  - Twiddle index k = b mod 2^s.
  - rom_addr = (2^s − 1) + k, so stage s uses addresses 2^s−1 .. 2^(s+1)−2.
  - bf_top = ((b >> s) << (s+1)) | k.
  - bf_bot = bf_top + 2^s.
  - All computations are unsigned and never exceed 31.
- Issue rule: issue in RUN only when fifo_count + inflight < FIFO_DEPTH. An issue registers rom_addr and loads the meta pipe stage 1 (top, bot, stage, last).
- Capture: 2 edges after issue, rom_data plus the meta (advanced through 2 registers) are written to the FIFO. inflight counts issues not yet written (0..2).
- Pop: on bf_valid && bf_ready at an edge. bf_ready while bf_valid=0 is ignored.
- While bf_valid=1 and unaccepted, all bf_* outputs hold stable.
- Simultaneous write and pop: count is unchanged and the entry order is preserved.
- The credit rule guarantees the FIFO never overflows. No back-pressure reaches the ROM; rom_addr holds its last value when not issuing.
- start while busy or in DONE is ignored.
- Reset mid-pass:
  - All state returns to IDLE immediately.
  - FIFO is emptied and inflight is cleared.
  - No partial output survives.

## Timing
- Reset values:
  - busy=0, done=0, bf_valid=0, rom_addr=0.
  - bf_tw, bf_top, bf_bot, bf_stage and bf_last are 0.
  - State IDLE, counters 0.
- Start sequence:
  - start=1 at edge T: busy=1 after T.
  - First issue (rom_addr=0) at edge T+1.
  - First FIFO write at edge T+3; bf_valid=1 after T+3.
- Throughput: with bf_ready held high, one butterfly per cycle steady state.
- Stage transition: the first issue of stage s+1 occurs at the edge ending the DRAIN_CYC-th idle cycle. That idle count starts the cycle after the last pop of stage s.
- End of pass: done=1 and busy=0 together in the DONE cycle. IDLE follows on the next edge.
- bf_stage/bf_last always describe the current FIFO head, never the issue side.

## Test plan
- Reset with bf_ready=1, then a single start pulse -> stage 0 delivers 16 entries, all with addr 0, (top,bot)=(0,1),(2,3)..(30,31), bf_last only on the 16th. Stage 4 addresses run 15..30 with b=3 giving top 3, bot 19. Exactly 80 accepted entries, then one done pulse.
- ROM model returning 16'h0100+addr, with bf_ready=0 for 10 cycles after the first valid -> bf_valid and head stay stable, exactly 4 issues are outstanding, and rom_addr stops advancing. After release there are no lost or duplicated entries.
- Random bf_ready at 30% duty over a full pass -> the 80 entries arrive in order with the exact address/index sequence. The FIFO never exceeds 4 entries.
- Between stages, measured from the last pop to the next rom_addr change -> exactly DRAIN_CYC idle cycles. No issue occurs while the FIFO is non-empty.
- start pulses during RUN, DRAIN and DONE -> ignored, with no restart and no extra done.
- rst_n low for 1 cycle mid-stage 2 -> bf_valid=0, busy=0 and rom_addr=0 immediately. A new start then produces a clean pass from stage 0.
